k005297_bdi_deserializer: RTL and testbench
===========================================

Name: k005297_bdi_deserializer

Overview:
- Downstream stage of the invalid-page data generator.
- Takes the muxed bubble-data-in bit stream and assembles it, LSB-first, into bytes.
- Buffers the bytes in a small FIFO and hands them to the host/DMA write side with a valid/ready handshake.
- Tracks the byte count within a page, signals page completion and flags buffer overrun.

Parameters:
PAGE_BYTES, 64, number of bytes per bubble page; must be >= 1.
FIFO_DEPTH, 4, byte FIFO entries; must be a power of two, >= 2.

Ports:
i_MCLK  in  1  master clock
i_SYS_RST  in  1  synchronous reset, active-high
i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active-low; gates bit sampling and the FSM
i_PAGE_START  in  1  page start request, sampled on enable cycles
i_BIT_VALID  in  1  bit strobe (SR shift enable of the upstream stage)
i_MUXED_BDI  in  1  muxed bubble data bit
o_BYTE_DATA  out  8  FIFO head byte
o_BYTE_VALID  out  1  FIFO non-empty
i_BYTE_READY  in  1  consumer accepts the head byte
o_BYTE_CNT  out  $clog2(PAGE_BYTES)+1  bytes assembled in the current page
o_PAGE_DONE  out  1  one-MCLK pulse at page completion
o_OVERRUN  out  1  sticky: a byte was dropped because the FIFO was full
o_BUSY  out  1  FSM not in IDLE

Behaviour:
- Reset (i_SYS_RST=1 at a posedge, regardless of enable):
  - FSM goes to IDLE; FIFO emptied.
  - Shift register, bit counter and o_BYTE_CNT cleared.
  - o_BYTE_VALID=0, o_PAGE_DONE=0, o_OVERRUN=0, o_BUSY=0.
  - Reset mid-page discards all partial and buffered data.
- "Enable edge" means a posedge i_MCLK with i_CLK2M_PCEN_n=0. FSM, shift register, counters and FIFO pushes change only on enable edges. FIFO pops are not gated.
- FSM states: IDLE, RECV, DRAIN.
  - IDLE: i_PAGE_START=1 on an enable edge -> RECV. At the same time, clear the bit counter, o_BYTE_CNT and o_OVERRUN. The FIFO is not cleared.
  - RECV: on each enable edge with i_BIT_VALID=1:
    - sr <= {i_MUXED_BDI, sr[7:1]}, so the first bit received ends up in bit 0.
    - The bit counter increments, 3 bits, wrapping 7->0.
    - When the 8th bit is sampled, the completed byte {i_MUXED_BDI, sr[7:1]} is pushed on that same edge and o_BYTE_CNT increments.
    - When o_BYTE_CNT reaches PAGE_BYTES -> DRAIN.
  - RECV with i_PAGE_START=1: restart. The partial byte is discarded; bit counter and o_BYTE_CNT are cleared; o_OVERRUN is cleared; the FIFO is kept; state stays RECV. If start and the 8th bit coincide, start wins and no byte is pushed.
  - DRAIN: bits are ignored. When the FIFO is empty on an enable edge:
    - o_PAGE_DONE pulses high for exactly one MCLK cycle, on the following clock.
    - The FSM goes to IDLE.
    - i_PAGE_START in DRAIN is ignored.
- FIFO:
  - Push and pop pointers have FIFO_DEPTH entries plus a wrap bit.
  - o_BYTE_VALID and o_BYTE_DATA are registered from the FIFO head. A push into an empty FIFO makes o_BYTE_VALID=1 one MCLK after the push edge.
  - Pop: any posedge with o_BYTE_VALID & i_BYTE_READY. The head advances, and valid drops the next cycle if the FIFO becomes empty.
  - Push with FIFO full and no pop on the same edge: the byte is dropped, o_OVERRUN is set, and o_BYTE_CNT still increments.
  - Push and pop on the same edge while full: both happen, no overrun.
- o_BUSY=1 in RECV and DRAIN.
- o_BYTE_CNT saturates at PAGE_BYTES. It holds its value in DRAIN and IDLE until the next start.

Test Plan:
- Reset, start, 16 bits 1,0,1,0,0,0,0,0 then 1,1,1,1,1,1,1,1, with ready=1 -> bytes 0x05 then 0xFF; o_BYTE_CNT=2; no overrun.
- PAGE_BYTES=4, 32 bits, ready=1 -> 4 bytes, FSM enters DRAIN, single-cycle o_PAGE_DONE once the FIFO is empty, o_BUSY=0 afterwards.
- ready=0, FIFO_DEPTH=4, push 5 bytes -> FIFO holds the first 4, the 5th is dropped, o_OVERRUN=1, o_BYTE_CNT=5. Then ready=1 -> the first 4 bytes are delivered in order.
- FIFO full, and on the edge a 5th byte completes, pop with ready=1 -> no overrun; all 5 bytes are delivered in order.
- Start asserted after 5 bits of a byte -> partial discarded; the next 8 bits 0xA5 (sent LSB-first) are delivered as 0xA5; o_BYTE_CNT=1.
- Reset asserted mid-page with 2 bytes buffered -> o_BYTE_VALID=0, o_BUSY=0 and all counters at 0 on the next cycle. i_BIT_VALID pulses with the enable high are ignored throughout.

Source files
------------

// File: rtl/k005297_bdi_deserializer.sv
// k005297_bdi_deserializer
// Assembles the muxed bubble-data-in bit stream LSB-first into bytes. The bytes
// are buffered in a small FIFO and handed to the host/DMA write side over a
// valid/ready handshake. The block also counts the bytes of a page, pulses on
// page completion and flags bytes dropped because the FIFO was full.
//
// Ports
//   i_MCLK          master clock
//   i_SYS_RST       synchronous reset, active-high
//   i_CLK2M_PCEN_n  2 MHz clock enable, active-low (gates sampling, FSM, pushes)
//   i_PAGE_START    page start / restart request
//   i_BIT_VALID     bit strobe from the upstream shift stage
//   i_MUXED_BDI     muxed bubble data bit
//   o_BYTE_DATA     FIFO head byte (registered)
//   o_BYTE_VALID    FIFO head valid (registered)
//   i_BYTE_READY    consumer accepts the head byte (pops are not enable-gated)
//   o_BYTE_CNT      bytes assembled in the current page, saturating
//   o_PAGE_DONE     one-MCLK pulse once the page is complete and the FIFO drained
//   o_OVERRUN       sticky flag: a byte was dropped on a full FIFO
//   o_BUSY          FSM is in RECV or DRAIN
module k005297_bdi_deserializer #(
  parameter int unsigned PAGE_BYTES = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_MCLK,
  input  logic                          i_SYS_RST,
  input  logic                          i_CLK2M_PCEN_n,
  input  logic                          i_PAGE_START,
  input  logic                          i_BIT_VALID,
  input  logic                          i_MUXED_BDI,
  output logic [7:0]                    o_BYTE_DATA,
  output logic                          o_BYTE_VALID,
  input  logic                          i_BYTE_READY,
  output logic [$clog2(PAGE_BYTES):0]   o_BYTE_CNT,
  output logic                          o_PAGE_DONE,
  output logic                          o_OVERRUN,
  output logic                          o_BUSY
);

  localparam int unsigned CW = $clog2(PAGE_BYTES) + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  // Only the upper seven bits are kept; bit 0 is shifted out on every sample.
  logic [7:1]      r_sr;
  logic [2:0]      r_bit_cnt;
  logic [CW-1:0]   r_byte_cnt;
  logic            r_overrun;
  logic            r_page_done;
  logic            r_busy;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [7:0]      r_byte_data;
  logic            r_byte_valid;

  logic            w_en;
  logic            w_clear;
  logic            w_shift;
  logic            w_byte_done;
  logic            w_page_done_nxt;
  logic [7:0]      w_byte;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_drop;
  logic [PW-1:0]   w_rd_nxt;

  assign w_en      = ~i_CLK2M_PCEN_n;
  assign w_byte    = {i_MUXED_BDI, r_sr[7:1]};
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = ((r_wr_ptr - r_rd_ptr) == PW'(FIFO_DEPTH));
  assign w_pop     = r_byte_valid & i_BYTE_READY;
  // A pop on the same edge frees the slot the push needs.
  assign w_push_ok = w_byte_done & (~w_full | w_pop);
  assign w_drop    = w_byte_done & w_full & ~w_pop;
  assign w_rd_nxt  = r_rd_ptr + PW'(w_pop);

  // State register
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt     = r_state;
    w_clear         = 1'b0;
    w_shift         = 1'b0;
    w_byte_done     = 1'b0;
    w_page_done_nxt = 1'b0;
    if (w_en) begin
      case (r_state)
        ST_IDLE: begin
          if (i_PAGE_START) begin
            w_state_nxt = ST_RECV;
            w_clear     = 1'b1;
          end
        end
        ST_RECV: begin
          // A restart wins over a coinciding 8th bit.
          if (i_PAGE_START) begin
            w_clear = 1'b1;
          end else if (i_BIT_VALID) begin
            w_shift = 1'b1;
            if (r_bit_cnt == 3'd7) begin
              w_byte_done = 1'b1;
              if (r_byte_cnt == CW'(PAGE_BYTES - 1)) begin
                w_state_nxt = ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            w_state_nxt     = ST_IDLE;
            w_page_done_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Shift register, counters and status flags
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_overrun   <= 1'b0;
      r_page_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_clear) begin
        r_sr       <= '0;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_overrun  <= 1'b0;
      end else if (w_shift) begin
        r_sr      <= w_byte[7:1];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_done && (r_byte_cnt != CW'(PAGE_BYTES))) begin
          r_byte_cnt <= r_byte_cnt + CW'(1);
        end
        if (w_drop) begin
          r_overrun <= 1'b1;
        end
      end
      r_page_done <= w_page_done_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // FIFO storage; contents need no reset because the pointers define occupancy
  always_ff @(posedge i_MCLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_byte;
    end
  end

  // FIFO pointers and registered head. The head is taken from the post-pop read
  // pointer against the pre-push write pointer, so a fresh push shows up one
  // cycle later and a popped entry is never presented twice.
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr     <= w_rd_nxt;
      r_byte_valid <= (r_wr_ptr != w_rd_nxt);
      r_byte_data  <= r_mem[w_rd_nxt[AW-1:0]];
    end
  end

  assign o_BYTE_DATA  = r_byte_data;
  assign o_BYTE_VALID = r_byte_valid;
  assign o_BYTE_CNT   = r_byte_cnt;
  assign o_PAGE_DONE  = r_page_done;
  assign o_OVERRUN    = r_overrun;
  assign o_BUSY       = r_busy;

endmodule

// File: tb/tb_k005297_bdi_deserializer.sv
// Bench for k005297_bdi_deserializer: a 64-byte-page instance and a 4-byte-page
// instance share all inputs; each test resets both and checks the relevant one.
module tb_k005297_bdi_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pcen_n, start, bv, bdi, ready;
  logic [7:0] data, data4;
  logic       valid, valid4, pd, pd4, ovr, ovr4, busy, busy4;
  logic [6:0] cnt;
  logic [2:0] cnt4;

  k005297_bdi_deserializer #(.PAGE_BYTES(64), .FIFO_DEPTH(4)) u_dut (
    .i_MCLK(clk), .i_SYS_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_PAGE_START(start),
    .i_BIT_VALID(bv), .i_MUXED_BDI(bdi), .o_BYTE_DATA(data), .o_BYTE_VALID(valid),
    .i_BYTE_READY(ready), .o_BYTE_CNT(cnt), .o_PAGE_DONE(pd), .o_OVERRUN(ovr),
    .o_BUSY(busy));

  k005297_bdi_deserializer #(.PAGE_BYTES(4), .FIFO_DEPTH(4)) u_dut4 (
    .i_MCLK(clk), .i_SYS_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_PAGE_START(start),
    .i_BIT_VALID(bv), .i_MUXED_BDI(bdi), .o_BYTE_DATA(data4), .o_BYTE_VALID(valid4),
    .i_BYTE_READY(ready), .o_BYTE_CNT(cnt4), .o_PAGE_DONE(pd4), .o_OVERRUN(ovr4),
    .o_BUSY(busy4));

  int total = 0;
  int bad   = 0;
  logic [7:0] got[$];
  logic [7:0] got4[$];
  bit rnd_mode = 1'b0;
  bit spur     = 1'b0;

  typedef struct {
    logic [7:0] seq;  // bits in send order, first-sent bit is the MSB
    logic [7:0] exp;  // byte the consumer must receive
  } vec_t;
  vec_t tbl[6];

  // Consumer-side monitor: a byte is delivered when valid & ready before an edge
  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) got.push_back(data);
    if (valid4 === 1'b1 && ready === 1'b1) got4.push_back(data4);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send_bit(input logic b);
    if (spur && $urandom_range(0, 2) == 0) begin
      pcen_n = 1'b1; bv = 1'b1; bdi = ($urandom_range(0, 1) == 1);
      tick();
      bv = 1'b0;
    end
    pcen_n = 1'b0; bv = 1'b1; bdi = b;
    tick();
    pcen_n = 1'b1; bv = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_seq(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic pulse_start();
    pcen_n = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; pcen_n = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_got(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 300) begin
      tick();
      k++;
    end
    chk(name, got.size(), n);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic       pend[$];
    logic [7:0] bv8;
    int         cnt_exp, npd;

    rst = 1'b0; pcen_n = 1'b1; start = 1'b0; bv = 1'b0; bdi = 1'b0; ready = 1'b0;
    tbl[0] = '{8'b10100000, 8'h05};
    tbl[1] = '{8'b11111111, 8'hFF};
    tbl[2] = '{8'b10100101, 8'hA5};
    tbl[3] = '{8'b00000001, 8'h80};
    tbl[4] = '{8'b11000000, 8'h03};
    tbl[5] = '{8'b01111000, 8'h1E};
    tick();

    // Reset state and table-driven byte assembly
    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_pd", pd, 0);
    ready = 1'b1;
    got.delete();
    pulse_start();
    chk("start_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      send_seq(tbl[i].seq);
      chk($sformatf("tbl_cnt%0d", i), cnt, i + 1);
    end
    wait_got(6, "tbl_count");
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk($sformatf("tbl_byte%0d", i), got[i], tbl[i].exp);
    end
    chk("tbl_ovr", ovr, 0);

    // Page completion on the 4-byte-page instance
    do_reset();
    got4.delete();
    ready = 1'b1;
    pulse_start();
    send_bits(8'h12, 8); send_bits(8'h34, 8); send_bits(8'h56, 8); send_bits(8'h78, 8);
    chk("page_busy_drain", busy4, 1);
    chk("page_cnt", cnt4, 4);
    chk("page_pd_early", pd4, 0);
    pcen_n = 1'b0;
    npd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pd4 === 1'b1) npd++;
    end
    pcen_n = 1'b1;
    chk("page_pd_pulses", npd, 1);
    chk("page_busy_after", busy4, 0);
    chk("page_cnt_hold", cnt4, 4);
    chk("page_n_bytes", got4.size(), 4);
    if (got4.size() == 4) begin
      chk("page_b0", got4[0], 8'h12);
      chk("page_b3", got4[3], 8'h78);
    end

    // Overrun: five bytes into a four-entry FIFO with no consumer
    do_reset();
    got.delete();
    ready = 1'b0;
    pulse_start();
    for (int i = 1; i <= 5; i++) send_bits(8'(i * 8'h11), 8);
    chk("ovr_flag", ovr, 1);
    chk("ovr_cnt", cnt, 5);
    chk("ovr_valid", valid, 1);
    chk("ovr_head", data, 8'h11);
    ready = 1'b1;
    wait_got(4, "ovr_drain_count");
    repeat (10) tick();
    chk("ovr_no_extra", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("ovr_byte%0d", i), got[i], 8'((i + 1) * 8'h11));
    end
    chk("ovr_sticky", ovr, 1);

    // Full FIFO: push of the 5th byte and a pop on the same edge
    do_reset();
    got.delete();
    ready = 1'b0;
    pulse_start();
    for (int i = 1; i <= 4; i++) send_bits(8'(i * 8'h11), 8);
    send_bits(8'h55, 7);
    ready = 1'b1; pcen_n = 1'b0; bv = 1'b1; bdi = 1'b0;
    tick();
    ready = 1'b0; pcen_n = 1'b1; bv = 1'b0;
    chk("pp_ovr", ovr, 0);
    chk("pp_cnt", cnt, 5);
    ready = 1'b1;
    wait_got(5, "pp_count");
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk($sformatf("pp_byte%0d", i), got[i], 8'((i + 1) * 8'h11));
    end

    // Restart: coinciding with an 8th bit, then after 5 bits of a byte
    do_reset();
    got.delete();
    ready = 1'b1;
    pulse_start();
    send_bits(8'hFF, 7);
    pcen_n = 1'b0; start = 1'b1; bv = 1'b1; bdi = 1'b1;
    tick();
    pcen_n = 1'b1; start = 1'b0; bv = 1'b0;
    chk("rs_coinc_cnt", cnt, 0);
    send_bits(8'h1F, 5);
    pulse_start();
    send_bits(8'hA5, 8);
    wait_got(1, "rs_count");
    repeat (10) tick();
    chk("rs_only_one", got.size(), 1);
    if (got.size() > 0) chk("rs_byte", got[0], 8'hA5);
    chk("rs_cnt", cnt, 1);

    // Reset mid-page with two bytes buffered; strobes without enable are ignored
    do_reset();
    got.delete();
    ready = 1'b0;
    pulse_start();
    send_bits(8'h3C, 8); send_bits(8'hC3, 8); send_bits(8'h07, 3);
    chk("mr_valid_before", valid, 1);
    do_reset();
    chk("mr_valid", valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cnt", cnt, 0);
    chk("mr_ovr", ovr, 0);
    for (int i = 0; i < 8; i++) begin
      bv = 1'b1; bdi = 1'(i);
      tick();
    end
    bv = 1'b0;
    chk("mr_idle_busy", busy, 0);
    chk("mr_idle_valid", valid, 0);
    ready = 1'b1;
    spur = 1'b1;
    pulse_start();
    send_bits(8'h5A, 8);
    spur = 1'b0;
    wait_got(1, "mr_count");
    if (got.size() > 0) chk("mr_byte", got[0], 8'h5A);

    // Randomized stream against a byte-stream model
    do_reset();
    got.delete();
    exp_q.delete();
    pend.delete();
    cnt_exp = 0;
    rnd_mode = 1'b1;
    spur = 1'b1;
    pulse_start();
    for (int it = 0; it < 180; it++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulse_start();
        pend.delete();
        cnt_exp = 0;
      end else begin
        logic b;
        b = ($urandom_range(0, 1) == 1);
        repeat ($urandom_range(0, 2)) tick();
        send_bit(b);
        pend.push_back(b);
        if (pend.size() == 8) begin
          bv8 = '0;
          for (int j = 0; j < 8; j++) bv8 = bv8 | (8'(pend[j]) << j);
          exp_q.push_back(bv8);
          pend.delete();
          cnt_exp++;
        end
      end
    end
    rnd_mode = 1'b0;
    spur = 1'b0;
    ready = 1'b1;
    wait_got(exp_q.size(), "rnd_count");
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("rnd_byte%0d", i), got[i], exp_q[i]);
    end
    chk("rnd_cnt", cnt, cnt_exp);
    chk("rnd_ovr", ovr, 0);
    chk("rnd_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
